// File: rtl/tfm_pkg.sv
// Shared types and helpers for the twiddle-factor complex multiplier.
//   tfm_mode_e : per-sample twiddle mode (forward / inverse conjugate)
//   rnd_sat()  : round-half-up by frac_bits, then clamp to a data_width signed word
package tfm_pkg;

  typedef enum logic {
    TFM_FWD = 1'b0,
    TFM_INV = 1'b1
  } tfm_mode_e;

  // Largest supported data word; products are twice that, sums one bit more.
  localparam int unsigned DataWidthMax  = 31;
  localparam int unsigned ProdWidthMax  = 2 * DataWidthMax;
  // Working width of rnd_sat: holds any sum plus rounding carry without wrap.
  localparam int unsigned RsWidth       = ProdWidthMax + 2;

  typedef struct packed {
    logic [RsWidth-1:0] word;
    logic               ovf;
  } rnd_sat_t;

  function automatic rnd_sat_t rnd_sat(input logic signed [RsWidth-1:0] value,
                                       input int unsigned               frac_bits,
                                       input int unsigned               data_width);
    logic signed [RsWidth-1:0] half;
    logic signed [RsWidth-1:0] rounded;
    logic signed [RsWidth-1:0] max_v;
    logic signed [RsWidth-1:0] min_v;
    rnd_sat_t                  res;
    half    = RsWidth'(1) <<< (frac_bits - 1);
    rounded = (value + half) >>> frac_bits;
    max_v   = (RsWidth'(1) <<< (data_width - 1)) - RsWidth'(1);
    min_v   = -max_v - RsWidth'(1);
    if (rounded > max_v) begin
      res.word = max_v;
      res.ovf  = 1'b1;
    end else if (rounded < min_v) begin
      res.word = min_v;
      res.ovf  = 1'b1;
    end else begin
      res.word = rounded;
      res.ovf  = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/tfm_rnd_sat.sv
// Combinational round-and-saturate of one complex component.
//   sum_i : full-precision signed sum (2*DATA_WIDTH+1 bits)
//   res_o : rounded, clamped DATA_WIDTH-bit word
//   sat_o : high when the clamp was applied
module tfm_rnd_sat
  import tfm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 15
) (
  input  logic signed [2*DATA_WIDTH:0]   sum_i,
  output logic signed [DATA_WIDTH-1:0]   res_o,
  output logic                           sat_o
);

  logic signed [RsWidth-1:0] sum_ext;
  rnd_sat_t                  rs;
  logic                      unused_hi;

  always_comb begin
    sum_ext = RsWidth'(sum_i);
    rs      = rnd_sat(sum_ext, FRAC_BITS, DATA_WIDTH);
    res_o   = rs.word[DATA_WIDTH-1:0];
    sat_o   = rs.ovf;
  end

  // Upper bits are a sign copy after clamping.
  assign unused_hi = ^rs.word[RsWidth-1:DATA_WIDTH];

endmodule

// File: rtl/tfm_cplx_pipe.sv
// Three-stage pipelined twiddle multiplier with valid/ready and global stall.
//   clk, rst (sync, active-low)
//   in_val/in_rdy, inv, cos_theta, sin_theta, data_re, data_im, tag_in : input sample
//   out_val/out_rdy, out_re, out_im, tag_out                           : result
//   ovf (sticky saturation flag), ovf_clr (synchronous clear, loses to a new set)
module tfm_cplx_pipe
  import tfm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 15,
  parameter int unsigned TAG_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_val,
  output logic                         in_rdy,
  input  logic                         inv,
  input  logic signed [DATA_WIDTH-1:0] cos_theta,
  input  logic signed [DATA_WIDTH-1:0] sin_theta,
  input  logic signed [DATA_WIDTH-1:0] data_re,
  input  logic signed [DATA_WIDTH-1:0] data_im,
  input  logic        [TAG_WIDTH-1:0]  tag_in,
  output logic                         out_val,
  input  logic                         out_rdy,
  output logic signed [DATA_WIDTH-1:0] out_re,
  output logic signed [DATA_WIDTH-1:0] out_im,
  output logic        [TAG_WIDTH-1:0]  tag_out,
  output logic                         ovf,
  input  logic                         ovf_clr
);

  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned SW = PW + 1;

  logic ce;
  logic v1_q, v2_q, v3_q;

  // Stage 1
  logic signed [PW-1:0]   p_ac_q, p_bs_q, p_bc_q, p_as_q;
  tfm_mode_e              mode_q;
  logic [TAG_WIDTH-1:0]   tag1_q;
  // Stage 2
  logic signed [SW-1:0]   re_sum_d, im_sum_d, re_sum_q, im_sum_q;
  logic [TAG_WIDTH-1:0]   tag2_q;
  // Stage 3
  logic signed [DATA_WIDTH-1:0] re_rs, im_rs, out_re_q, out_im_q;
  logic                         sat_re, sat_im;
  logic [TAG_WIDTH-1:0]         tag3_q;
  logic                         ovf_q;

  // A stalled, unconsumed output freezes the whole pipe; ready is combinational.
  assign ce     = ~v3_q | out_rdy;
  assign in_rdy = ce;

  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (ce) begin
      v1_q <= in_val;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && ce && in_val) begin
      p_ac_q <= data_re * cos_theta;
      p_bs_q <= data_im * sin_theta;
      p_bc_q <= data_im * cos_theta;
      p_as_q <= data_re * sin_theta;
      mode_q <= tfm_mode_e'(inv);
      tag1_q <= tag_in;
    end
  end

  always_comb begin
    if (mode_q == TFM_INV) begin
      re_sum_d = SW'(p_ac_q) - SW'(p_bs_q);
      im_sum_d = SW'(p_bc_q) + SW'(p_as_q);
    end else begin
      re_sum_d = SW'(p_ac_q) + SW'(p_bs_q);
      im_sum_d = SW'(p_bc_q) - SW'(p_as_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && ce && v1_q) begin
      re_sum_q <= re_sum_d;
      im_sum_q <= im_sum_d;
      tag2_q   <= tag1_q;
    end
  end

  tfm_rnd_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_rs_re (
    .sum_i (re_sum_q),
    .res_o (re_rs),
    .sat_o (sat_re)
  );

  tfm_rnd_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_rs_im (
    .sum_i (im_sum_q),
    .res_o (im_rs),
    .sat_o (sat_im)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_re_q <= '0;
      out_im_q <= '0;
      tag3_q   <= '0;
    end else if (ce && v2_q) begin
      out_re_q <= re_rs;
      out_im_q <= im_rs;
      tag3_q   <= tag2_q;
    end
  end

  // Set takes priority over clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (ce && v2_q && (sat_re || sat_im)) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign out_val = v3_q;
  assign out_re  = out_re_q;
  assign out_im  = out_im_q;
  assign tag_out = tag3_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_tfm_cplx_pipe.sv
// Scoreboard bench for tfm_cplx_pipe: directed vectors push expected results,
// a negedge monitor pops and compares on every output transfer.
module tb_tfm_cplx_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_val = 1'b0;
  logic        inv = 1'b0;
  logic        out_rdy = 1'b1;
  logic        ovf_clr = 1'b0;
  logic [15:0] cos_theta = '0, sin_theta = '0, data_re = '0, data_im = '0;
  logic [7:0]  tag_in = '0;
  logic        in_rdy, out_val, ovf;
  logic [15:0] out_re, out_im;
  logic [7:0]  tag_out;

  tfm_cplx_pipe #(
    .DATA_WIDTH (16),
    .FRAC_BITS  (15),
    .TAG_WIDTH  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .inv       (inv),
    .cos_theta (cos_theta),
    .sin_theta (sin_theta),
    .data_re   (data_re),
    .data_im   (data_im),
    .tag_in    (tag_in),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_re    (out_re),
    .out_im    (out_im),
    .tag_out   (tag_out),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic [7:0]  tag;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  bit   rst_edge = 1'b0;
  bit   hold_prev = 1'b0;
  logic [15:0] prev_re, prev_im;
  logic [7:0]  prev_tag;
  bit   ov_hist[1024];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_edge = rst;
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (cyc < 1024) ov_hist[cyc] = out_val;
    if (rst) begin
      if (out_val && !out_rdy) chk("in_rdy_low_on_stall", {31'd0, in_rdy}, 32'd0);
      if (hold_prev && rst_edge) begin
        chk("hold_re", {16'd0, out_re}, {16'd0, prev_re});
        chk("hold_im", {16'd0, out_im}, {16'd0, prev_im});
        chk("hold_tag", {24'd0, tag_out}, {24'd0, prev_tag});
      end
      if (out_val && out_rdy) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_output: got tag %0h, required no output", tag_out);
        end else begin
          e = q.pop_front();
          chk("out_re", {16'd0, out_re}, {16'd0, e.re});
          chk("out_im", {16'd0, out_im}, {16'd0, e.im});
          chk("tag_out", {24'd0, tag_out}, {24'd0, e.tag});
          if (e.lat) chk("latency", cyc - e.acc, 32'd3);
        end
      end
    end
    hold_prev = rst && out_val && !out_rdy;
    prev_re   = out_re;
    prev_im   = out_im;
    prev_tag  = tag_out;
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic iv, input logic [15:0] c, input logic [15:0] s,
                      input logic [15:0] a, input logic [15:0] b, input logic [7:0] tg,
                      input logic [15:0] er, input logic [15:0] ei, input bit lat);
    int n;
    n = 0;
    inv = iv; cos_theta = c; sin_theta = s; data_re = a; data_im = b; tag_in = tg;
    in_val = 1'b1;
    @(negedge clk);
    while (!in_rdy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_rdy) begin
      n_chk++;
      $display("FAIL accept_timeout: in_rdy=0 after 200 cycles, required 1");
    end else begin
      q.push_back('{re: er, im: ei, tag: tg, acc: cyc, lat: lat});
    end
    sync();
    in_val = 1'b0;
  endtask

  task automatic idle(input int n);
    in_val = 1'b0;
    repeat (n) sync();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      sync();
      n++;
    end
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int b0;
    bit pat[5];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_val", {31'd0, out_val}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_out_re", {16'd0, out_re}, 32'd0);
    chk("rst_out_im", {16'd0, out_im}, 32'd0);
    chk("rst_tag_out", {24'd0, tag_out}, 32'd0);
    sync();
    rst = 1'b1;
    sync();

    // Unity twiddle, latency checked
    send(1'b0, 16'h7FFF, 16'h0000, 16'h4000, 16'h2000, 8'h5A, 16'h4000, 16'h2000, 1'b1);
    drain();
    chk("ovf_unity", {31'd0, ovf}, 32'd0);

    // Quarter rotation, forward then inverse
    send(1'b0, 16'h0000, 16'h8000, 16'h1234, 16'h0100, 8'h01, 16'hFF00, 16'h1234, 1'b0);
    send(1'b1, 16'h0000, 16'h8000, 16'h1234, 16'h0100, 8'h02, 16'h0100, 16'hEDCC, 1'b0);
    drain();

    // Saturation and sticky flag clear
    send(1'b0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 8'h03, 16'h7FFF, 16'h0000, 1'b0);
    drain();
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    ovf_clr = 1'b1;
    sync();
    ovf_clr = 1'b0;
    chk("ovf_cleared", {31'd0, ovf}, 32'd0);

    // Back-pressure: unity twiddle passes small positive values unchanged
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(1'b0, 16'h7FFF, 16'h0000, 16'(i * 256), 16'(4096 + i), 8'(i),
               16'(i * 256), 16'(4096 + i), 1'b0);
      end
      begin
        repeat (5) sync();
        out_rdy = 1'b0;
        repeat (4) sync();
        out_rdy = 1'b1;
      end
    join
    drain();

    // Bubbles: in_val 1,0,1,1,0
    b0 = cyc;
    send(1'b0, 16'h7FFF, 16'h0000, 16'h0020, 16'h0021, 8'h20, 16'h0020, 16'h0021, 1'b1);
    idle(1);
    send(1'b0, 16'h7FFF, 16'h0000, 16'h0030, 16'h0031, 8'h21, 16'h0030, 16'h0031, 1'b1);
    send(1'b0, 16'h7FFF, 16'h0000, 16'h0040, 16'h0041, 8'h22, 16'h0040, 16'h0041, 1'b1);
    idle(1);
    drain();
    idle(4);
    for (int k = 0; k < 5; k++)
      chk($sformatf("bubble_out_val_%0d", k), {31'd0, ov_hist[b0 + 3 + k]}, {31'd0, pat[k]});

    // Reset with three samples in flight (output held by out_rdy=0)
    out_rdy = 1'b0;
    inv = 1'b0; cos_theta = 16'h7FFF; sin_theta = 16'h0000;
    data_re = 16'h0123; data_im = 16'h0456;
    for (int i = 0; i < 3; i++) begin
      tag_in = 8'(8'hE0 + i);
      in_val = 1'b1;
      sync();
    end
    in_val = 1'b0;
    @(negedge clk);
    chk("full_before_rst", {31'd0, out_val}, 32'd1);
    #1;
    rst = 1'b0;
    sync();
    rst = 1'b1;
    out_rdy = 1'b1;
    @(negedge clk);
    chk("midrst_out_val", {31'd0, out_val}, 32'd0);
    chk("midrst_out_re", {16'd0, out_re}, 32'd0);
    chk("midrst_out_im", {16'd0, out_im}, 32'd0);
    chk("midrst_ovf", {31'd0, ovf}, 32'd0);
    sync();
    idle(6);

    // Recovery after reset
    send(1'b0, 16'h7FFF, 16'h0000, 16'h0200, 16'h0300, 8'h77, 16'h0200, 16'h0300, 1'b1);
    drain();
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
